// File: rtl/usb2_ep_pkg.sv
// Shared constants for the USB2 endpoint ring: endpoint types, data PID encodings,
// ring FSM states and the data-toggle sequencing helper.
package usb2_ep_pkg;

    localparam logic [1:0] EP_MODE_CONTROL   = 2'd0;
    localparam logic [1:0] EP_MODE_ISOCH     = 2'd1;
    localparam logic [1:0] EP_MODE_BULK      = 2'd2;
    localparam logic [1:0] EP_MODE_INTERRUPT = 2'd3;

    localparam logic [1:0] DATA_TOGGLE_DATA0 = 2'd0;
    localparam logic [1:0] DATA_TOGGLE_DATA1 = 2'd1;
    localparam logic [1:0] DATA_TOGGLE_DATA2 = 2'd2;
    localparam logic [1:0] DATA_TOGGLE_MDATA = 2'd3;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } ring_state_e;

    // Isoch high-bandwidth endpoints count down DATA2/DATA1 toward DATA0; others ping-pong.
    function automatic logic [1:0] next_toggle(
        input logic [1:0] cur,
        input logic [1:0] mode,
        input logic [1:0] iso_mult,
        input logic       act,
        input logic       rst
    );
        logic [1:0] nxt;
        nxt = cur;
        if (rst) begin
            if (mode == EP_MODE_ISOCH) begin
                case (iso_mult)
                    2'd2:    nxt = DATA_TOGGLE_DATA1;
                    2'd3:    nxt = DATA_TOGGLE_DATA2;
                    default: nxt = DATA_TOGGLE_DATA0;
                endcase
            end else begin
                nxt = DATA_TOGGLE_DATA0;
            end
        end else if (act) begin
            if (mode == EP_MODE_ISOCH) begin
                case (cur)
                    DATA_TOGGLE_DATA2: nxt = DATA_TOGGLE_DATA1;
                    default:           nxt = DATA_TOGGLE_DATA0;
                endcase
            end else begin
                nxt = (cur == DATA_TOGGLE_DATA0) ? DATA_TOGGLE_DATA1 : DATA_TOGGLE_DATA0;
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/usb2_ep_ring_ram.sv
// Simple dual-port byte RAM backing all ring buffers; one write port, one registered read port.
module usb2_ep_ring_ram
    import usb2_ep_pkg::*;
#(
    parameter int  NUM_BUF   = 4,
    parameter int  BUF_BYTES = 1024,
    localparam int RAW       = $clog2(NUM_BUF * BUF_BYTES)
) (
    input  logic           clk,
    input  logic           we,
    input  logic [RAW-1:0] waddr,
    input  logic [7:0]     wdata,
    input  logic [RAW-1:0] raddr,
    output logic [7:0]     rdata
);

    logic [7:0] mem [NUM_BUF * BUF_BYTES];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/usb2_ep_ring.sv
// usb2_ep_ring: ring of NUM_BUF packet buffers with per-buffer length and data-toggle tracking.
// Define USB2_EP_RING_OVF_EN to add the ovf_sticky / ovf_cnt overflow diagnostics.
module usb2_ep_ring
    import usb2_ep_pkg::*;
#(
    parameter int  NUM_BUF   = 4,
    parameter int  BUF_BYTES = 1024,
    localparam int AW        = $clog2(BUF_BYTES),
    localparam int PW        = $clog2(NUM_BUF)
) (
    input  logic          phy_clk,
    input  logic          reset_n,
    input  logic [AW-1:0] buf_in_addr,
    input  logic [7:0]    buf_in_data,
    input  logic          buf_in_wren,
    output logic          buf_in_ready,
    input  logic          buf_in_commit,
    input  logic [AW:0]   buf_in_commit_len,
    output logic          buf_in_commit_ack,
    input  logic [AW-1:0] buf_out_addr,
    output logic [7:0]    buf_out_q,
    output logic [AW:0]   buf_out_len,
    output logic          buf_out_hasdata,
    input  logic          buf_out_arm,
    output logic          buf_out_arm_ack,
    input  logic          flush,
    input  logic [1:0]    mode,
    input  logic [1:0]    iso_mult,
    input  logic          data_toggle_act,
    input  logic          data_toggle_rst,
    output logic [1:0]    data_toggle,
    output logic [PW:0]   buf_count
`ifdef USB2_EP_RING_OVF_EN
    ,
    output logic          ovf_sticky,
    output logic [7:0]    ovf_cnt
`endif
);

    localparam logic [PW:0] FULL_CNT = NUM_BUF[PW:0];

    ring_state_e state_q, state_d;
    logic [PW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0] count, next_count;
    logic        ready_q, ready_d, hasdata_q, hasdata_d;
    logic        commit_ack_q, commit_ack_d, arm_ack_q, arm_ack_d;
    logic [AW:0] buf_out_len_q, buf_out_len_d;
    logic [1:0]  data_toggle_q, data_toggle_d;
    logic        full, empty, commit_ok, arm_ok;
    logic [AW:0] len_q [NUM_BUF];
`ifdef USB2_EP_RING_OVF_EN
    logic        ovf_sticky_q, ovf_sticky_d;
    logic [7:0]  ovf_cnt_q, ovf_cnt_d;
`endif

    always_comb begin
        count         = wr_ptr_q - rd_ptr_q;
        full          = (count == FULL_CNT);
        empty         = (count == '0);
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        next_count    = count;
        ready_d       = ready_q;
        hasdata_d     = hasdata_q;
        commit_ack_d  = 1'b0;
        arm_ack_d     = 1'b0;
        buf_out_len_d = buf_out_len_q;
        commit_ok     = 1'b0;
        arm_ok        = 1'b0;
        case (state_q)
            ST_INIT: begin
                state_d       = ST_RUN;
                wr_ptr_d      = '0;
                rd_ptr_d      = '0;
                ready_d       = 1'b1;
                hasdata_d     = 1'b0;
                buf_out_len_d = '0;
            end
            ST_RUN: begin
                if (flush) begin
                    state_d       = ST_INIT;
                    wr_ptr_d      = '0;
                    rd_ptr_d      = '0;
                    ready_d       = 1'b0;
                    hasdata_d     = 1'b0;
                    buf_out_len_d = '0;
                end else begin
                    // A release in the same cycle frees a slot, so a full ring may still accept a commit.
                    arm_ok       = buf_out_arm & ~empty;
                    commit_ok    = buf_in_commit & (~full | arm_ok);
                    wr_ptr_d     = wr_ptr_q + {{PW{1'b0}}, commit_ok};
                    rd_ptr_d     = rd_ptr_q + {{PW{1'b0}}, arm_ok};
                    next_count   = wr_ptr_d - rd_ptr_d;
                    ready_d      = (next_count != FULL_CNT);
                    hasdata_d    = (next_count != '0);
                    commit_ack_d = commit_ok;
                    arm_ack_d    = arm_ok;
                    if (commit_ok && (rd_ptr_d[PW-1:0] == wr_ptr_q[PW-1:0])) begin
                        buf_out_len_d = buf_in_commit_len;
                    end else begin
                        buf_out_len_d = len_q[rd_ptr_d[PW-1:0]];
                    end
                end
            end
            default: state_d = ST_INIT;
        endcase
        data_toggle_d = next_toggle(data_toggle_q, mode, iso_mult, data_toggle_act, data_toggle_rst);
`ifdef USB2_EP_RING_OVF_EN
        ovf_sticky_d = ovf_sticky_q;
        ovf_cnt_d    = ovf_cnt_q;
        if (state_q == ST_RUN) begin
            if (flush) begin
                ovf_sticky_d = 1'b0;
            end else begin
                if ((buf_in_commit & ~commit_ok) | (buf_out_arm & ~arm_ok)) begin
                    ovf_sticky_d = 1'b1;
                end
                if (buf_in_commit & ~commit_ok & (ovf_cnt_q != 8'hFF)) begin
                    ovf_cnt_d = ovf_cnt_q + 8'd1;
                end
            end
        end
`endif
    end

    always_ff @(posedge phy_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_INIT;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            ready_q       <= 1'b0;
            hasdata_q     <= 1'b0;
            commit_ack_q  <= 1'b0;
            arm_ack_q     <= 1'b0;
            buf_out_len_q <= '0;
            data_toggle_q <= DATA_TOGGLE_DATA0;
`ifdef USB2_EP_RING_OVF_EN
            ovf_sticky_q  <= 1'b0;
            ovf_cnt_q     <= 8'd0;
`endif
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            ready_q       <= ready_d;
            hasdata_q     <= hasdata_d;
            commit_ack_q  <= commit_ack_d;
            arm_ack_q     <= arm_ack_d;
            buf_out_len_q <= buf_out_len_d;
            data_toggle_q <= data_toggle_d;
`ifdef USB2_EP_RING_OVF_EN
            ovf_sticky_q  <= ovf_sticky_d;
            ovf_cnt_q     <= ovf_cnt_d;
`endif
        end
    end

    // Buffer lengths deliberately survive reset and flush; only the pointers say which are live.
    always_ff @(posedge phy_clk) begin
        if (commit_ok) begin
            len_q[wr_ptr_q[PW-1:0]] <= buf_in_commit_len;
        end
    end

    usb2_ep_ring_ram #(
        .NUM_BUF   (NUM_BUF),
        .BUF_BYTES (BUF_BYTES)
    ) u_ram (
        .clk   (phy_clk),
        .we    (buf_in_wren & ~full),
        .waddr ({wr_ptr_q[PW-1:0], buf_in_addr}),
        .wdata (buf_in_data),
        .raddr ({rd_ptr_q[PW-1:0], buf_out_addr}),
        .rdata (buf_out_q)
    );

    assign buf_in_ready      = ready_q;
    assign buf_out_hasdata   = hasdata_q;
    assign buf_in_commit_ack = commit_ack_q;
    assign buf_out_arm_ack   = arm_ack_q;
    assign buf_out_len       = buf_out_len_q;
    assign data_toggle       = data_toggle_q;
    assign buf_count         = count;
`ifdef USB2_EP_RING_OVF_EN
    assign ovf_sticky        = ovf_sticky_q;
    assign ovf_cnt           = ovf_cnt_q;
`endif

endmodule

// File: doc/usb2_ep_ring.md
USB2_EP_RING -- requirements
Module: usb2_ep_ring

Interface
REQ-001 SHALL have parameter NUM_BUF, default 4, number of ring buffers (power of two, 2..8).
REQ-002 SHALL have parameter BUF_BYTES, default 1024, bytes per buffer (power of two, 64..1024).
REQ-003 SHALL have derived localparams AW = log2(BUF_BYTES) and PW = log2(NUM_BUF).
REQ-004 phy_clk  in  1  single clock for all logic and RAM.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 buf_in_addr / buf_in_data / buf_in_wren  in  AW / 8 / 1  byte write into the current write buffer.
REQ-007 buf_in_ready  out  1  a free buffer exists for writing.
REQ-008 buf_in_commit / buf_in_commit_len  in  1 / AW+1  one-cycle pulse that closes the write buffer with its length.
REQ-009 buf_in_commit_ack  out  1  one-cycle acceptance pulse.
REQ-010 buf_out_addr / buf_out_q  in / out  AW / 8  read of the current read buffer.
REQ-011 buf_out_len / buf_out_hasdata  out  AW+1 / 1  length and valid flag of the head buffer.
REQ-012 buf_out_arm / buf_out_arm_ack  in / out  1 / 1  one-cycle release of the head buffer, and its acceptance pulse.
REQ-013 flush  in  1  one-cycle pulse that discards all buffers.
REQ-014 mode / iso_mult  in  2 / 2  endpoint type (0 control, 1 isoch, 2 bulk, 3 interrupt) and isoch transactions per microframe (1..3).
REQ-015 data_toggle_act / data_toggle_rst  in  1 / 1  advance the PID sequence, or restart it.
REQ-016 data_toggle  out  2  PID encoding: 0 DATA0, 1 DATA1, 2 DATA2, 3 MDATA.
REQ-017 buf_count  out  PW+1  number of committed, unreleased buffers.

Function
REQ-018 SHALL keep wr_ptr and rd_ptr of PW+1 bits each; count = wr_ptr - rd_ptr.
  - full: count == NUM_BUF; empty: count == 0.
REQ-019 RAM write address SHALL be {wr_ptr[PW-1:0], buf_in_addr}; read address SHALL be {rd_ptr[PW-1:0], buf_out_addr}.
REQ-020 buf_out_q SHALL appear 1 cycle after buf_out_addr.
REQ-021 Writes to a full ring SHALL be suppressed.
REQ-022 buf_in_ready SHALL equal ~full, registered; buf_out_hasdata SHALL equal ~empty, registered.
REQ-023 Commit accepted when not full: store buf_in_commit_len into len[wr_ptr], increment wr_ptr, pulse buf_in_commit_ack the next cycle.
REQ-024 Commit while full SHALL be ignored: no ack, no state change.
REQ-025 Arm accepted when not empty: increment rd_ptr, pulse buf_out_arm_ack the next cycle.
REQ-026 Arm while empty SHALL be ignored.
REQ-027 Commit and arm in the same cycle SHALL both take effect; a commit while full SHALL be accepted if an arm is accepted in the same cycle.
REQ-028 buf_out_len SHALL equal len[rd_ptr], updated the cycle after any pointer change.
REQ-029 FSM states SHALL be ST_INIT and ST_RUN.
  - ST_INIT: pointers cleared, ready=0, hasdata=0; exits to ST_RUN after 1 cycle.
  - flush in ST_RUN SHALL enter ST_INIT; flush has priority over commit and arm in the same cycle.
REQ-030 Data toggle for control/bulk/interrupt: data_toggle_act alternates DATA0/DATA1.
REQ-031 Data toggle for isoch: data_toggle_rst loads DATA0/DATA1/DATA2 for iso_mult 1/2/3; each act decrements toward DATA0 and holds at DATA0; iso_mult 0 SHALL be treated as 1.
REQ-032 data_toggle_rst SHALL override data_toggle_act in the same cycle; non-isoch rst loads DATA0.

Reset
REQ-033 Reset SHALL clear asynchronously:
  - state to ST_INIT, pointers 0, data_toggle DATA0;
  - ready, hasdata, both acks 0, buf_out_len 0, buf_count 0.
REQ-034 Reset SHALL NOT clear RAM contents or the len array.
REQ-035 Deassertion mid-transfer SHALL leave the ring empty and ready after 2 cycles.

Configuration
REQ-036 With USB2_EP_RING_OVF_EN defined, the block SHALL add:
  - output ovf_sticky (1): set by a rejected commit or a rejected arm, cleared by flush or reset;
  - output ovf_cnt (8): saturating count of rejected commits.
REQ-037 Without USB2_EP_RING_OVF_EN, neither port nor any related logic SHALL exist.

Structure
REQ-038 Package usb2_ep_pkg SHALL hold:
  - the EP_MODE_* constants;
  - the DATA_TOGGLE_* PID constants;
  - the FSM state typedef.
REQ-039 Sub-module usb2_ep_ring_ram SHALL be simple dual-port, NUM_BUF*BUF_BYTES x 8, 1-cycle registered read.

Verification
REQ-040 NUM_BUF=4: commit 4 buffers with lengths 10/20/30/40 -> buf_count=4, ready=0, buf_out_len=10; arm 4 times -> lengths seen 20, 30, 40, then hasdata=0.
REQ-041 Full ring plus a 5th commit -> no ack, buf_count stays 4; with OVF_EN, ovf_cnt=1 and ovf_sticky=1.
REQ-042 Full ring with simultaneous commit and arm -> both acks pulse, buf_count stays 4, wr_ptr and rd_ptr wrap correctly.
REQ-043 Write bytes 0xA5 at addr 0 and 0x5A at addr BUF_BYTES-1, then commit -> buf_out_q returns both values 1 cycle after each address.
REQ-044 Isoch, iso_mult=3: rst then 3 acts -> DATA2, DATA1, DATA0, DATA0; bulk: acts -> DATA0, DATA1, DATA0.
REQ-045 Flush, or reset_n pulsed low, with 3 buffers queued -> buf_count=0, hasdata=0, ready=1 within 2 cycles.
